remote_comm: RTL and testbench
==============================

# remote_comm

Host-side counterpart to the robot's UART command interface. It accepts a 16-bit command, serializes it over UART as two 8N1 bytes (high byte first), then captures the single response byte (0xA5 done / 0x5A in progress) coming back on RX. It is used as the bench-side and "phone" model that drives the Knight's Tour top level, and can also be synthesized as a remote controller.

## Interface
- BAUD_DIV, 434: clocks per bit (50 MHz / 115200); legal range 16..4095.
- TMO_CYC, 2500000: response timeout in clocks; used only when RESP_TMO_EN is defined.

- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- cmd  input  16  command to send; latched on snd_cmd.
- snd_cmd  input  1  one-cycle start strobe.
- busy  output  1  high while either command byte is being transmitted.
- cmd_snt  output  1  sticky; set when the low-byte stop bit completes; cleared by the next accepted snd_cmd.
- TX  output  1  UART serial out, idle high.
- RX  input  1  UART serial in, asynchronous.
- resp  output  8  last correctly framed received byte.
- resp_rdy  output  1  sticky; set on a good byte; cleared by accepted snd_cmd.
- resp_tmo  output  1  sticky timeout flag; tied 0 without RESP_TMO_EN.

## Operation
- Reset values: TX=1, busy=0, cmd_snt=0, resp=8'h00, resp_rdy=0, resp_tmo=0; RX synchronizer flops preset to 1.
- TX FSM: IDLE -> TX_HI -> TX_LO -> IDLE (with the macro: -> WAIT_RESP -> IDLE).
  - IDLE: snd_cmd latches cmd into a 16-bit holding register, clears cmd_snt, resp_rdy and resp_tmo, and goes to TX_HI.
  - TX_HI: sends cmd[15:8]. When its stop bit ends, goes to TX_LO.
  - TX_LO: sends cmd[7:0]. When its stop bit ends, sets cmd_snt and exits.
- Frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts BAUD_DIV clocks.
- snd_cmd outside IDLE is ignored: no relatch, flags untouched.
- RX path: runs independently of the TX FSM (full duplex).
  - RX is double-flopped. A falling edge in RX idle starts a frame.
  - The start bit is re-checked at BAUD_DIV/2; if it is high, the frame is a false start and the receiver returns to idle.
  - Data and stop bits are sampled at mid-bit.
  - Stop bit 1: resp is loaded and resp_rdy is set.
  - Stop bit 0: the byte is discarded and resp is unchanged.
- A byte arriving during TX is still captured. If snd_cmd is accepted in the same cycle resp_rdy would be set, the set wins.
- Counters: baud counter 12 bits; bit counter 4 bits, counting 0..9.

## Timing
- TX drops to the start bit 1 cycle after snd_cmd is sampled in IDLE.
- busy rises in that same cycle.
- The low byte's start bit follows the high byte's stop bit with no gap.
- cmd_snt rises, and busy falls, 20*BAUD_DIV+1 cycles after the snd_cmd cycle.
- resp_rdy rises 1 cycle after the stop-bit mid-sample, about 9.5*BAUD_DIV+3 cycles after the RX falling edge (2 synchronizer cycles included).
- Reset mid-operation: all state returns to reset values immediately (asynchronous); no partial frame resumes.

## Configuration
- RESP_TMO_EN defined:
  - After TX_LO the FSM enters WAIT_RESP and a 22-bit counter runs.
  - A good response byte returns the FSM to IDLE.
  - If TMO_CYC clocks elapse with no good byte, resp_tmo is set and the FSM returns to IDLE.
  - snd_cmd is ignored during WAIT_RESP.
- RESP_TMO_EN undefined:
  - No WAIT_RESP state and no timeout counter; resp_tmo is constant 0.
  - The FSM returns to IDLE directly after TX_LO.

## Structure
- Package remote_comm_pkg holds:
  - the FSM state enum (tx_state_t);
  - the default BAUD_DIV and TMO_CYC;
  - the response constants RESP_DONE=8'hA5 and RESP_BUSY=8'h5A.
- Sub-module uart_xcvr contains the 8N1 transmitter (trmt/tx_data/tx_done) and receiver (rx_data/rx_rdy), parameterized by BAUD_DIV.
- remote_comm keeps the byte-sequencing FSM, the holding register, the sticky flags and the timeout logic.

## Test plan
All scenarios use BAUD_DIV=16 unless noted.
- Send: snd_cmd with cmd=16'h2A5B -> TX carries frame 0x2A, then 0x5B, back to back; cmd_snt rises at cycle 321; busy is high cycles 1..320.
- Receive: drive RX with byte 0xA5 -> resp=8'hA5 and resp_rdy=1. A following 0x5A -> resp=8'h5A.
- Busy ignore: second snd_cmd with 16'hFFFF at cycle 50 -> transmitted bytes remain 0x2A, 0x5B.
- Framing error: RX byte 0x3C with stop bit 0 -> resp_rdy stays 0 and resp unchanged. A false start glitch shorter than 8 cycles is also ignored.
- Reset mid-byte: rst_n low at cycle 100 -> TX=1, busy=0, cmd_snt=0 immediately; a new send afterwards completes normally.
- RESP_TMO_EN with TMO_CYC=1000: no response -> resp_tmo=1 at 1000 cycles after cmd_snt. With 0xA5 returned earlier -> resp_tmo stays 0.

Source files
------------

// File: rtl/remote_comm_pkg.sv
// Shared types and constants for the remote_comm UART command sender.
// The WAIT_RESP state exists only when RESP_TMO_EN is defined.
package remote_comm_pkg;

    localparam int BAUD_DIV_DFLT = 434;
    localparam int TMO_CYC_DFLT  = 2500000;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

`ifdef RESP_TMO_EN
    typedef enum logic [1:0] {IDLE, TX_HI, TX_LO, WAIT_RESP} tx_state_t;
`else
    typedef enum logic [1:0] {IDLE, TX_HI, TX_LO} tx_state_t;
`endif

endpackage

// File: rtl/uart_xcvr.sv
// Full-duplex 8N1 UART: trmt starts a frame on the next cycle, tx_done flags the last stop-bit cycle.
// No backpressure: rx_rdy is a one-cycle pulse with rx_data valid only during that pulse.
module uart_xcvr
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DFLT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       TX,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rx_rdy
);

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);

    logic [9:0]  tx_shft_q;
    logic [11:0] tx_baud_q;
    logic [3:0]  tx_bit_q;
    logic        tx_act_q;

    // Combinational so the caller can chain the next frame with no idle gap.
    assign tx_done = tx_act_q && (tx_baud_q == BAUD_LAST) && (tx_bit_q == 4'd9);
    assign TX      = tx_shft_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shft_q <= '1;
            tx_baud_q <= '0;
            tx_bit_q  <= '0;
            tx_act_q  <= 1'b0;
        end else if (trmt) begin
            tx_shft_q <= {1'b1, tx_data, 1'b0};
            tx_baud_q <= '0;
            tx_bit_q  <= '0;
            tx_act_q  <= 1'b1;
        end else if (tx_act_q) begin
            if (tx_baud_q == BAUD_LAST) begin
                tx_baud_q <= '0;
                tx_shft_q <= {1'b1, tx_shft_q[9:1]};
                if (tx_bit_q == 4'd9) begin
                    tx_bit_q <= '0;
                    tx_act_q <= 1'b0;
                end else begin
                    tx_bit_q <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_baud_q <= tx_baud_q + 12'd1;
            end
        end
    end

    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic        rx_act_q;
    logic [11:0] rx_baud_q;
    logic [3:0]  rx_bit_q;
    logic [7:0]  rx_shft_q;
    logic        rx_rdy_q;
    logic [11:0] rx_tgt;

    // First interval lands mid start bit; later ones step a full bit.
    assign rx_tgt  = (rx_bit_q == 4'd0) ? HALF_LAST : BAUD_LAST;
    assign rx_data = rx_shft_q;
    assign rx_rdy  = rx_rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_act_q  <= 1'b0;
            rx_baud_q <= '0;
            rx_bit_q  <= '0;
            rx_shft_q <= '0;
            rx_rdy_q  <= 1'b0;
        end else begin
            rx_s1_q   <= RX;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rx_rdy_q  <= 1'b0;
            if (!rx_act_q) begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_act_q  <= 1'b1;
                    rx_baud_q <= '0;
                    rx_bit_q  <= '0;
                end
            end else if (rx_baud_q == rx_tgt) begin
                rx_baud_q <= '0;
                rx_bit_q  <= rx_bit_q + 4'd1;
                if (rx_bit_q == 4'd0) begin
                    if (rx_s2_q) rx_act_q <= 1'b0;
                end else if (rx_bit_q == 4'd9) begin
                    rx_act_q <= 1'b0;
                    rx_bit_q <= '0;
                    if (rx_s2_q) rx_rdy_q <= 1'b1;
                end else begin
                    rx_shft_q <= {rx_s2_q, rx_shft_q[7:1]};
                end
            end else begin
                rx_baud_q <= rx_baud_q + 12'd1;
            end
        end
    end

endmodule

// File: rtl/remote_comm.sv
// Sends a 16-bit command as two back-to-back 8N1 bytes and captures the response byte; done 20*BAUD_DIV+1 cycles after snd_cmd.
// snd_cmd is dropped unless idle; RESP_TMO_EN adds a response wait with timeout flag.
module remote_comm
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DFLT,
    parameter int TMO_CYC  = TMO_CYC_DFLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        busy,
    output logic        cmd_snt,
    output logic        TX,
    input  logic        RX,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    output logic        resp_tmo
);

    if (BAUD_DIV < 16 || BAUD_DIV > 4095 || TMO_CYC < 1 || TMO_CYC > 4194303) begin : g_bad_param
        $error("remote_comm: BAUD_DIV or TMO_CYC out of range");
    end

    tx_state_t   state_q;
    logic [15:0] hold_q;
    logic        busy_q, cmd_snt_q, resp_rdy_q;
    logic [7:0]  resp_q;
    logic        accept, trmt, tx_done, rx_rdy;
    logic [7:0]  tx_data, rx_data;

    assign accept = (state_q == IDLE) && snd_cmd;
    assign trmt   = accept || ((state_q == TX_HI) && tx_done);

    // High byte comes straight from cmd so the start bit leaves one cycle after the strobe.
    always_comb begin
        tx_data = hold_q[15:8];
        case (state_q)
            IDLE:    tx_data = cmd[15:8];
            TX_HI:   tx_data = hold_q[7:0];
            default: tx_data = hold_q[15:8];
        endcase
    end

    uart_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .tx_done (tx_done),
        .TX      (TX),
        .RX      (RX),
        .rx_data (rx_data),
        .rx_rdy  (rx_rdy)
    );

`ifdef RESP_TMO_EN
    logic [21:0] tmo_cnt_q;
    logic        resp_tmo_q;
    assign resp_tmo = resp_tmo_q;
`else
    assign resp_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            busy_q     <= 1'b0;
            cmd_snt_q  <= 1'b0;
            resp_q     <= '0;
            resp_rdy_q <= 1'b0;
`ifdef RESP_TMO_EN
            tmo_cnt_q  <= '0;
            resp_tmo_q <= 1'b0;
`endif
        end else begin
            if (rx_rdy) resp_q <= rx_data;
            if (rx_rdy)      resp_rdy_q <= 1'b1;
            else if (accept) resp_rdy_q <= 1'b0;
            case (state_q)
                IDLE: if (snd_cmd) begin
                    hold_q    <= cmd;
                    cmd_snt_q <= 1'b0;
                    busy_q    <= 1'b1;
                    state_q   <= TX_HI;
`ifdef RESP_TMO_EN
                    resp_tmo_q <= 1'b0;
`endif
                end
                TX_HI: if (tx_done) state_q <= TX_LO;
                TX_LO: if (tx_done) begin
                    cmd_snt_q <= 1'b1;
                    busy_q    <= 1'b0;
`ifdef RESP_TMO_EN
                    tmo_cnt_q <= '0;
                    state_q   <= WAIT_RESP;
`else
                    state_q   <= IDLE;
`endif
                end
`ifdef RESP_TMO_EN
                WAIT_RESP: begin
                    if (rx_rdy) begin
                        state_q <= IDLE;
                    end else if (tmo_cnt_q == 22'(TMO_CYC - 1)) begin
                        resp_tmo_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 22'd1;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign cmd_snt  = cmd_snt_q;
    assign resp     = resp_q;
    assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm at BAUD_DIV=16; inputs driven and outputs sampled on the falling edge.
module tb_remote_comm;
    import remote_comm_pkg::*;

    localparam int B         = 16;
    localparam int TMO       = 1000;
    localparam int FRAME_CYC = 20 * B;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cmd = '0;
    logic        snd_cmd = 1'b0;
    logic        busy, cmd_snt, TX;
    logic        RX = 1'b1;
    logic [7:0]  resp;
    logic        resp_rdy, resp_tmo;
    logic        rdy_early;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    remote_comm #(.BAUD_DIV(B), .TMO_CYC(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (cmd),
        .snd_cmd  (snd_cmd),
        .busy     (busy),
        .cmd_snt  (cmd_snt),
        .TX       (TX),
        .RX       (RX),
        .resp     (resp),
        .resp_rdy (resp_rdy),
        .resp_tmo (resp_tmo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe c, optionally inject a 16'hFFFF strobe at cycle 'inject', and check both frames bit by bit.
    task automatic send_check(input string tag, input logic [15:0] c, input logic [7:0] hi,
                              input logic [7:0] lo, input int inject);
        logic       tx_hist [0:FRAME_CYC+1];
        logic [9:0] f_hi, f_lo;
        cmd     = c;
        snd_cmd = 1'b1;
        for (int n = 1; n <= FRAME_CYC + 1; n++) begin
            @(negedge clk);
            tx_hist[n] = TX;
            snd_cmd = (n == inject);
            if (n == inject) cmd = 16'hFFFF;
            if (n == 1) begin
                check({tag, "_tx_start"}, TX, 1'b0);
                check({tag, "_busy_rise"}, busy, 1'b1);
                check({tag, "_snt_clr"}, cmd_snt, 1'b0);
                check({tag, "_tmo_clr"}, resp_tmo, 1'b0);
            end
            if (n == FRAME_CYC) begin
                check({tag, "_busy_last"}, busy, 1'b1);
                check({tag, "_snt_early"}, cmd_snt, 1'b0);
            end
            if (n == FRAME_CYC + 1) begin
                check({tag, "_snt_set"}, cmd_snt, 1'b1);
                check({tag, "_busy_fall"}, busy, 1'b0);
            end
        end
        for (int k = 0; k < 10; k++) begin
            f_hi[k] = tx_hist[1 + k * B + B / 2];
            f_lo[k] = tx_hist[1 + (10 + k) * B + B / 2];
        end
        check({tag, "_frame_hi"}, f_hi, {1'b1, hi, 1'b0});
        check({tag, "_frame_lo"}, f_lo, {1'b1, lo, 1'b0});
    endtask

    // Drive one RX frame; 'early' samples resp_rdy a few cycles before the stop-bit mid-sample.
    task automatic rx_byte(input logic [7:0] d, input logic stop, output logic early);
        logic [9:0] fr;
        fr    = {stop, d, 1'b0};
        early = 1'bx;
        for (int t = 0; t < 10 * B; t++) begin
            RX = fr[t / B];
            if (t == 9 * B + 6) early = resp_rdy;
            @(negedge clk);
        end
        RX = 1'b1;
        cycles(4);
    endtask

    initial begin
        cycles(3);
        check("rst_tx", TX, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_snt", cmd_snt, 1'b0);
        check("rst_resp", resp, 8'h00);
        check("rst_rdy", resp_rdy, 1'b0);
        check("rst_tmo", resp_tmo, 1'b0);
        rst_n = 1'b1;
        cycles(2);

        rx_byte(RESP_DONE, 1'b1, rdy_early);
        check("rx1_early", rdy_early, 1'b0);
        check("rx1_rdy", resp_rdy, 1'b1);
        check("rx1_resp", resp, 8'hA5);
        rx_byte(RESP_BUSY, 1'b1, rdy_early);
        check("rx2_resp", resp, 8'h5A);

        send_check("send", 16'h2A5B, 8'h2A, 8'h5B, 0);
        check("send_rdy_clr", resp_rdy, 1'b0);
        rx_byte(RESP_DONE, 1'b1, rdy_early);
        check("rx3_resp", resp, 8'hA5);

        send_check("ignore", 16'h2A5B, 8'h2A, 8'h5B, 50);
        check("ignore_rdy_clr", resp_rdy, 1'b0);

        rx_byte(8'h3C, 1'b0, rdy_early);
        check("ferr_rdy", resp_rdy, 1'b0);
        check("ferr_resp", resp, 8'hA5);

        RX = 1'b0;
        cycles(5);
        RX = 1'b1;
        cycles(10 * B + 20);
        check("glitch_rdy", resp_rdy, 1'b0);
        check("glitch_resp", resp, 8'hA5);

        rx_byte(RESP_BUSY, 1'b1, rdy_early);
        check("rx4_rdy", resp_rdy, 1'b1);
        check("rx4_resp", resp, 8'h5A);

        cmd     = 16'h1234;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        cycles(99);
        check("mid_busy", busy, 1'b1);
        check("mid_tx", TX, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_tx", TX, 1'b1);
        check("arst_busy", busy, 1'b0);
        check("arst_snt", cmd_snt, 1'b0);
        check("arst_resp", resp, 8'h00);
        check("arst_rdy", resp_rdy, 1'b0);
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        send_check("after_rst", 16'hC3E1, 8'hC3, 8'hE1, 0);

`ifdef RESP_TMO_EN
        cycles(TMO - 1);
        check("tmo_not_yet", resp_tmo, 1'b0);
        cycles(1);
        check("tmo_set", resp_tmo, 1'b1);
        send_check("tmo2", 16'h0F0F, 8'h0F, 8'h0F, 0);
        rx_byte(RESP_DONE, 1'b1, rdy_early);
        cycles(TMO + 200);
        check("tmo_answered", resp_tmo, 1'b0);
        check("tmo_answered_resp", resp, 8'hA5);
`else
        cycles(TMO + 50);
        check("tmo_off", resp_tmo, 1'b0);
        check("idle_tx", TX, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
